menu_scroller: RTL and testbench
================================

# menu_scroller

- Produces the 28-bit `display_menu` word that the display multiplexer shows on the four large digits while the game FSM is in WLCM.
- Scrolls a fixed welcome message, "HOLA HEROE" followed by two blanks, right-to-left through a 4-digit window at a programmable step rate.
- Sits directly upstream of the display multiplexer and is driven by the same `presente` state bus.

## Interface
Parameters:
- `STEP_DIV`, default 24'd8_100_000: clock cycles per scroll step (0.3 s at 27 MHz). Legal range 2..2^24-1.

Ports:
- `clk`  input  1: system clock. One clock domain only.
- `rst_n`  input  1: reset, asynchronous, active-low.
- `presente`  input  3: game FSM state (OFF=0, WLCM=1, CH=2, GAME=3, WL=4, PA=5).
- `display_menu`  output  28: window, packed as {digit3, digit2, digit1, digit0}.
  - Each digit is 7 bits, active-high, bit0=a … bit6=g.
  - digit0 is the leftmost character.

## Operation
- Message ROM: 12 entries, MSG_LEN=12.
  - Indices 0..11 = H 7'h76, O 7'h3F, L 7'h38, A 7'h77, blank 7'h00, H 7'h76, E 7'h79, r 7'h50, O 7'h3F, E 7'h79, blank 7'h00, blank 7'h00.
- Registers:
  - `step_cnt` [23:0], `idx` [3:0], `display_menu` [27:0].
  - With blink configured: `state`, `blink_cnt` [2:0].
- When `presente` is anything other than WLCM:
  - `step_cnt`, `idx` and `blink_cnt` are cleared, and `state` is set to SCROLL.
  - `display_menu` is loaded with 28'd0 on the next edge.
- When `presente` is WLCM:
  - `step_cnt` increments each cycle.
  - When `step_cnt == STEP_DIV-1`, `step_cnt` is cleared and a step event fires.
- Step event in SCROLL: `idx` becomes `idx+1`. When `idx` is 11 it wraps to 0.
- Window: digit k = ROM[(idx+k) mod 12], for k = 0..3. The modulo wraps across the end of the message.
- `display_menu` is registered and reloaded every WLCM cycle from the current `idx` (or forced to 0 in BLINK off-phases).

## Timing
- Reset: `display_menu`=0, `idx`=0, `step_cnt`=0, `state`=SCROLL, `blink_cnt`=0, all asynchronously.
- Entry into WLCM at edge N (first cycle with `presente`=WLCM): `display_menu` shows the idx-0 window after edge N+1.
- Step event on the edge where `step_cnt` rolls over:
  - `idx` updates on that edge.
  - The new window appears one edge later (1-cycle output latency).
- Each window is held for exactly STEP_DIV cycles in steady state.
- Leaving WLCM mid-scroll: the output is 0 after the next edge, and the scroll restarts from idx 0 on re-entry.
- Asserting `rst_n` mid-operation clears all state immediately, with no partial frame.
- `presente` values 6 and 7 are treated as non-WLCM.

## Configuration
- `MENU_BLINK_EN` undefined: continuous scrolling only. No `state` or `blink_cnt` registers are built.
- `MENU_BLINK_EN` defined: a two-state FSM (SCROLL, BLINK) is built.
  - SCROLL → BLINK on the step event that wraps `idx` from 11 to 0. `blink_cnt` is cleared on that transition.
  - In BLINK, each step event increments `blink_cnt`.
  - Output is 0 while `blink_cnt` is even and the idx-0 window while it is odd.
  - On the step event where `blink_cnt == 5`, go back to SCROLL with `idx` still 0. The idx-0 window is then held for one full step before advancing.
  - `idx` does not change while in BLINK.
  - Leaving WLCM forces SCROLL.

## Structure
- Shared package `heroe_pkg` holds:
  - FSM state constants (OFF..PA).
  - Glyph constants (GLY_H, GLY_O, GLY_L, GLY_A, GLY_E, GLY_R, GLY_BLANK).
  - MSG_LEN.
  - The scroller state encoding (SCROLL=0, BLINK=1).
- The display multiplexer imports the same package for OFF..PA.
- One sub-module, `menu_glyph_rom`: combinational 4-bit index → 7-bit glyph, with an out-of-range index giving 7'h00. It is instantiated four times for the window.

## Test plan
All scenarios use STEP_DIV=4.
1. Reset with `presente`=OFF, held 10 cycles: `display_menu` stays 28'h0000000.
2. Switch `presente` to WLCM:
   - One edge later `display_menu`=28'hEEE1FF6 (H,O,L,A).
   - Four cycles after that it is 28'h01DDC3F (O,L,A,blank).
3. Stay in WLCM through 11 steps: `display_menu`=28'h70FFB00 (blank,H,O,L). The next step returns to 28'hEEE1FF6 (macro undefined).
4. Drop `presente` to GAME while `idx`=5:
   - The next edge gives 28'h0.
   - Re-entering WLCM shows 28'hEEE1FF6 after one edge.
5. Pulse `rst_n` low asynchronously mid-step: `display_menu` goes to 0 immediately, without waiting for a clock edge.
6. With `MENU_BLINK_EN` defined, after the 11→0 wrap the output sequence per 4-cycle step is 0, EEE1FF6, 0, EEE1FF6, 0, EEE1FF6, then EEE1FF6, then 01DDC3F.

Source files
------------

// File: rtl/heroe_pkg.sv
// Shared definitions: game FSM states, 7-segment glyphs and scroller state encoding.
package heroe_pkg;

  // Game FSM states carried on the presente bus
  localparam logic [2:0] OFF  = 3'd0;
  localparam logic [2:0] WLCM = 3'd1;
  localparam logic [2:0] CH   = 3'd2;
  localparam logic [2:0] GAME = 3'd3;
  localparam logic [2:0] WL   = 3'd4;
  localparam logic [2:0] PA   = 3'd5;

  // Active-high segment patterns, bit0=a .. bit6=g
  localparam logic [6:0] GLY_H     = 7'h76;
  localparam logic [6:0] GLY_O     = 7'h3F;
  localparam logic [6:0] GLY_L     = 7'h38;
  localparam logic [6:0] GLY_A     = 7'h77;
  localparam logic [6:0] GLY_E     = 7'h79;
  localparam logic [6:0] GLY_R     = 7'h50;
  localparam logic [6:0] GLY_BLANK = 7'h00;

  localparam int unsigned MSG_LEN = 12;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic {
    SCROLL = 1'b0,
    BLINK  = 1'b1
  } scroll_state_e;

  // Message index of window position off, wrapping across the end of the message
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input logic [1:0]       off);
    logic [IDX_W:0] sum;
    sum = {1'b0, base} + (IDX_W+1)'(off);
    if (sum >= (IDX_W+1)'(MSG_LEN)) sum = sum - (IDX_W+1)'(MSG_LEN);
    return sum[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/menu_glyph_rom.sv
// Welcome message ROM: message index to 7-segment glyph, out-of-range reads blank.
module menu_glyph_rom
  import heroe_pkg::*;
(
  input  logic [IDX_W-1:0] index,
  output logic [6:0]       glyph_c
);

  // "HOLA HEROE" followed by two blanks
  always_comb begin
    glyph_c = GLY_BLANK;
    case (index)
      4'd0:    glyph_c = GLY_H;
      4'd1:    glyph_c = GLY_O;
      4'd2:    glyph_c = GLY_L;
      4'd3:    glyph_c = GLY_A;
      4'd4:    glyph_c = GLY_BLANK;
      4'd5:    glyph_c = GLY_H;
      4'd6:    glyph_c = GLY_E;
      4'd7:    glyph_c = GLY_R;
      4'd8:    glyph_c = GLY_O;
      4'd9:    glyph_c = GLY_E;
      4'd10:   glyph_c = GLY_BLANK;
      4'd11:   glyph_c = GLY_BLANK;
      default: glyph_c = GLY_BLANK;
    endcase
  end

endmodule

// File: rtl/menu_scroller.sv
// Welcome-screen scroller: slides the message through the 4-digit window while in WLCM.
// Optional build macro MENU_BLINK_EN adds a blink phase after each full pass.
module menu_scroller
  import heroe_pkg::*;
#(
  parameter logic [23:0] STEP_DIV = 24'd8_100_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  presente,
  output logic [27:0] display_menu
);

  logic [23:0]      step_cnt, step_cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [27:0]      menu_nxt;
  logic [6:0]       glyph [4];
  logic             in_wlcm, step_evt, scrolling, blank;

`ifdef MENU_BLINK_EN
  scroll_state_e state, state_nxt;
  logic [2:0]    blink_cnt, blink_cnt_nxt;
`endif

  // Four ROM taps, one per window digit; digit0 is the leftmost character
  for (genvar k = 0; k < 4; k++) begin : g_rom
    menu_glyph_rom u_rom (
      .index   (wrap_idx(idx, 2'(k))),
      .glyph_c (glyph[k])
    );
  end

  // Step timing, scroll index and blink sequencing; window/blank selection for the output
  always_comb begin
    in_wlcm      = (presente == WLCM);
    step_evt     = in_wlcm && (step_cnt == STEP_DIV - 24'd1);
    step_cnt_nxt = step_cnt;
    idx_nxt      = idx;
`ifdef MENU_BLINK_EN
    state_nxt     = state;
    blink_cnt_nxt = blink_cnt;
    scrolling     = (state == SCROLL);
    blank         = (state == BLINK) && !blink_cnt[0];
`else
    scrolling     = 1'b1;
    blank         = 1'b0;
`endif

    if (!in_wlcm) begin
      step_cnt_nxt = '0;
      idx_nxt      = '0;
`ifdef MENU_BLINK_EN
      state_nxt     = SCROLL;
      blink_cnt_nxt = '0;
`endif
    end else begin
      step_cnt_nxt = step_evt ? '0 : step_cnt + 24'd1;
      if (step_evt) begin
        if (scrolling) begin
          if (idx == IDX_W'(MSG_LEN - 1)) begin
            idx_nxt = '0;
`ifdef MENU_BLINK_EN
            state_nxt     = BLINK;
            blink_cnt_nxt = '0;
`endif
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
`ifdef MENU_BLINK_EN
        else begin
          if (blink_cnt == 3'd5) begin
            state_nxt     = SCROLL;
            blink_cnt_nxt = '0;
          end else begin
            blink_cnt_nxt = blink_cnt + 3'd1;
          end
        end
`endif
      end
    end

    menu_nxt = (in_wlcm && !blank) ? {glyph[3], glyph[2], glyph[1], glyph[0]} : '0;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt     <= '0;
      idx          <= '0;
      display_menu <= '0;
`ifdef MENU_BLINK_EN
      state        <= SCROLL;
      blink_cnt    <= '0;
`endif
    end else begin
      step_cnt     <= step_cnt_nxt;
      idx          <= idx_nxt;
      display_menu <= menu_nxt;
`ifdef MENU_BLINK_EN
      state        <= state_nxt;
      blink_cnt    <= blink_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_menu_scroller.sv
// Bench for menu_scroller: directed scenarios plus random presente/reset traffic vs a step-count model.
module tb_menu_scroller;

  localparam int unsigned STEP = 4;
  localparam logic [2:0] P_OFF  = 3'd0;
  localparam logic [2:0] P_WLCM = 3'd1;
  localparam logic [2:0] P_GAME = 3'd3;
  localparam logic [27:0] W_HOLA = 28'hEEE1FF6;
  localparam logic [27:0] W_OLA  = 28'h01DDC3F;
  localparam logic [27:0] W_BHOL = 28'h70FFB00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  presente;
  logic [27:0] display_menu;

  int n_checks = 0;
  int n_errors = 0;
  int wl_cnt   = 0;   // edges spent in WLCM since entry (0 = not in WLCM)
  logic [27:0] exp_v;

  logic [6:0] msg [12] = '{7'h76, 7'h3F, 7'h38, 7'h77, 7'h00, 7'h76,
                           7'h79, 7'h50, 7'h3F, 7'h79, 7'h00, 7'h00};

  menu_scroller #(.STEP_DIV(24'd4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .presente     (presente),
    .display_menu (display_menu)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [27:0] got, input logic [27:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %07h expected %07h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [27:0] window(input int i);
    logic [27:0] w;
    for (int k = 0; k < 4; k++) w[k*7 +: 7] = msg[(i + k) % 12];
    return w;
  endfunction

  // Output after the c-th WLCM edge: step number decides which window is shown
  function automatic logic [27:0] model_out(input int c);
    int s;
    s = (c - 1) / STEP;
`ifdef MENU_BLINK_EN
    begin
      int p;
      p = s % 18;                       // 12 scroll steps then 6 blink steps
      if (p < 12) return window(p);
      if (((p - 12) % 2) == 0) return 28'd0;
      return window(0);
    end
`else
    return window(s % 12);
`endif
  endfunction

  // One clock with presente=p, model update and check
  task automatic cycle(input logic [2:0] p);
    presente = p;
    @(posedge clk);
    if (p == P_WLCM) wl_cnt++;
    else wl_cnt = 0;
    exp_v = (wl_cnt > 0) ? model_out(wl_cnt) : 28'd0;
    #1;
    check_eq("cycle", display_menu, exp_v);
  endtask

  task automatic run(input logic [2:0] p, input int n);
    for (int i = 0; i < n; i++) cycle(p);
  endtask

  // Mid-cycle asynchronous reset pulse spanning one clock edge
  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    wl_cnt = 0;
    #1 check_eq("async_rst", display_menu, 28'd0);
    @(posedge clk);
    #1 check_eq("rst_held", display_menu, 28'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    presente = P_OFF;
    #3 check_eq("reset", display_menu, 28'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle in OFF
    run(P_OFF, 10);
    check_eq("off_hold", display_menu, 28'd0);

    // Entry and first step
    cycle(P_WLCM);
    check_eq("entry", display_menu, W_HOLA);
    run(P_WLCM, 4);
    check_eq("step1", display_menu, W_OLA);

    // Last window of the pass, then the wrap
    run(P_WLCM, 40);
    check_eq("wrap_last", display_menu, W_BHOL);
`ifdef MENU_BLINK_EN
    begin
      logic [27:0] seq [8];
      seq = '{28'd0, W_HOLA, 28'd0, W_HOLA, 28'd0, W_HOLA, W_HOLA, W_OLA};
      for (int j = 0; j < 8; j++) begin
        run(P_WLCM, 4);
        check_eq("blink_seq", display_menu, seq[j]);
      end
    end
`else
    run(P_WLCM, 4);
    check_eq("wrap_first", display_menu, W_HOLA);
`endif

    // Leave WLCM at idx 5, then re-enter
    cycle(P_OFF);
    run(P_WLCM, 22);
    cycle(P_GAME);
    check_eq("drop", display_menu, 28'd0);
    cycle(P_WLCM);
    check_eq("reenter", display_menu, W_HOLA);

    // Out-of-range presente codes
    cycle(3'd6);
    check_eq("code6", display_menu, 28'd0);
    cycle(3'd7);
    check_eq("code7", display_menu, 28'd0);

    // Asynchronous reset mid-step
    run(P_WLCM, 6);
    reset_pulse();
    cycle(P_WLCM);
    check_eq("after_rst", display_menu, W_HOLA);

    // Random traffic
    for (int it = 0; it < 200; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) run(P_WLCM, $urandom_range(1, 90));
      else if (r < 9) begin
        int n;
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) cycle(3'($urandom_range(0, 7)));
      end else reset_pulse();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
